// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: write-port bundle between the requesters and the register-file write arbiter
// Signals: req/addr/data (packed per requester, requester-driven), gnt/reg_en/reg_data/conflict_cnt (arbiter-driven).
// Modports: master = requester side, slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int NREGS = 32,
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    addr;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic [NREGS-1:0]      reg_en;
    logic [WIDTH-1:0]      reg_data;
    logic [15:0]           conflict_cnt;
    modport master (output req, addr, data, input gnt, reg_en, reg_data, conflict_cnt);
    modport slave (input req, addr, data, output gnt, reg_en, reg_data, conflict_cnt);
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing the register-file write port among NREQ requesters
// Ports: clk, reset (synchronous, active-high); bus (slave modport): req/addr/data in, registered gnt/reg_en/reg_data out, conflict_cnt out.
// Define REGARB_CONFLICT_CNT_EN to build the saturating contention counter; otherwise conflict_cnt is tied to 0.
module regfile_write_arbiter #(
    parameter int NREQ  = 2,
    parameter int NREGS = 32,
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input logic                    clk,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    logic [PW-1:0]    ptr_q, ptr_d, win, idx;
    logic [NREQ-1:0]  last_q, elig, gnt_q, gnt_d;
    logic [NREGS-1:0] en_q, en_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    addr_a [NREQ];
    logic [WIDTH-1:0] data_a [NREQ];
    logic [AW-1:0]    wa;
    logic             found;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i] = bus.addr[i*AW +: AW];
        assign data_a[i] = bus.data[i*WIDTH +: WIDTH];
    end

    // the requester granted last cycle sits out one edge
    assign elig = bus.req & ~last_q;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        wa     = addr_a[win];
        gnt_d  = found ? NREQ'(1) << win : '0;
        // R0 and out-of-range writes are still granted but enable nothing
        en_d   = (found && wa != '0 && int'(wa) < NREGS) ? NREGS'(1) << wa : '0;
        data_d = found ? data_a[win] : '0;
        ptr_d  = !found ? ptr_q : (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            last_q <= '0;
            gnt_q  <= '0;
            en_q   <= '0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            last_q <= gnt_d;
            gnt_q  <= gnt_d;
            en_q   <= en_d;
            data_q <= data_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.reg_en   = en_q;
    assign bus.reg_data = data_q;

`ifdef REGARB_CONFLICT_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d = ($countones(elig) > 1 && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign bus.conflict_cnt = cnt_q;
`else
    assign bus.conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: table-driven scoreboard bench for regfile_write_arbiter (NREQ=2)
module tb_regfile_write_arbiter;
    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  g;
        logic [31:0] en;
        logic [31:0] dat;
        logic        conf;
    } vec_t;
    typedef struct {
        logic [1:0]  g;
        logic [31:0] en;
        logic [31:0] dat;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   run = 1'b0;
    vec_t v [$];
    exp_t sb [$];
    logic [15:0] ecnt = '0;

    regfile_write_arbiter_if #(.NREQ(2), .NREGS(32), .WIDTH(32), .AW(5)) bus ();
    regfile_write_arbiter #(.NREQ(2), .NREGS(32), .WIDTH(32), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic [1:0] req, logic [4:0] a0, logic [4:0] a1,
                                logic [31:0] d0, logic [31:0] d1, logic [1:0] g,
                                logic [31:0] en, logic [31:0] dat, logic conf);
        vec_t r;
        r.rst = rst; r.req = req; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
        r.g = g; r.en = en; r.dat = dat; r.conf = conf;
        return r;
    endfunction

    task automatic chk(string name, int step, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    // structural invariants checked every cycle while stimulus runs
    always @(negedge clk) begin
        if (run) begin
            total++;
            if (!($onehot0(bus.gnt) && $onehot0(bus.reg_en) && !bus.reg_en[0] &&
                  (bus.reg_en == '0 || bus.gnt != '0))) begin
                bad++;
                $display("FAIL invariant: gnt=%b reg_en=%h", bus.gnt, bus.reg_en);
            end
        end
    end

    initial begin
        exp_t e;
        bus.req = '0; bus.addr = '0; bus.data = '0;
        // single write, then idle
        v.push_back(mk(0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 2'b01, 32'h20, 32'hDEADBEEF, 0));
        v.push_back(mk(0, 2'b00, 5, 0, 32'hDEADBEEF, 0, 2'b00, 32'h0, 32'h0, 0));
        // contention: ptr=1 after first grant, so requester 1 wins first
        v.push_back(mk(0, 2'b11, 3, 7, 32'hA0, 32'hA1, 2'b10, 32'h80, 32'hA1, 1));
        v.push_back(mk(0, 2'b11, 3, 7, 32'hA0, 32'hA1, 2'b01, 32'h8, 32'hA0, 0));
        v.push_back(mk(0, 2'b11, 3, 7, 32'hA0, 32'hA1, 2'b10, 32'h80, 32'hA1, 0));
        v.push_back(mk(0, 2'b11, 3, 7, 32'hA0, 32'hA1, 2'b01, 32'h8, 32'hA0, 0));
        v.push_back(mk(0, 2'b00, 3, 7, 32'hA0, 32'hA1, 2'b00, 32'h0, 32'h0, 0));
        // write to R0: granted, no enable
        v.push_back(mk(0, 2'b01, 0, 0, 32'h1, 0, 2'b01, 32'h0, 32'h1, 0));
        // single requester held high: alternate-cycle grants
        v.push_back(mk(0, 2'b01, 9, 0, 32'h55, 0, 2'b00, 32'h0, 32'h0, 0));
        v.push_back(mk(0, 2'b01, 9, 0, 32'h55, 0, 2'b01, 32'h200, 32'h55, 0));
        v.push_back(mk(0, 2'b01, 9, 0, 32'h55, 0, 2'b00, 32'h0, 32'h0, 0));
        v.push_back(mk(0, 2'b01, 9, 0, 32'h55, 0, 2'b01, 32'h200, 32'h55, 0));
        // requester 1 writes R0, then top register 31
        v.push_back(mk(0, 2'b11, 9, 0, 32'h55, 32'h77, 2'b10, 32'h0, 32'h77, 0));
        v.push_back(mk(0, 2'b11, 9, 31, 32'h55, 32'h88, 2'b01, 32'h200, 32'h55, 0));
        v.push_back(mk(0, 2'b10, 9, 31, 32'h55, 32'h88, 2'b10, 32'h80000000, 32'h88, 0));
        v.push_back(mk(0, 2'b00, 9, 31, 32'h55, 32'h88, 2'b00, 32'h0, 32'h0, 0));
        // same address from both: serialized, requester 1 lands last
        v.push_back(mk(0, 2'b11, 2, 2, 32'h11, 32'h22, 2'b01, 32'h4, 32'h11, 1));
        v.push_back(mk(0, 2'b10, 2, 2, 32'h11, 32'h22, 2'b10, 32'h4, 32'h22, 0));
        v.push_back(mk(0, 2'b00, 2, 2, 32'h11, 32'h22, 2'b00, 32'h0, 32'h0, 0));
        // reset while a grant is in flight, then ptr restarts at 0
        v.push_back(mk(0, 2'b11, 4, 6, 32'h44, 32'h66, 2'b01, 32'h10, 32'h44, 1));
        v.push_back(mk(1, 2'b11, 4, 6, 32'h44, 32'h66, 2'b00, 32'h0, 32'h0, 0));
        v.push_back(mk(0, 2'b11, 4, 6, 32'h44, 32'h66, 2'b01, 32'h10, 32'h44, 1));
        v.push_back(mk(0, 2'b11, 4, 6, 32'h44, 32'h66, 2'b10, 32'h40, 32'h66, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", -1, 32'(bus.gnt), 32'h0);
        chk("rst_en", -1, bus.reg_en, 32'h0);
        chk("rst_data", -1, bus.reg_data, 32'h0);
        chk("rst_cnt", -1, 32'(bus.conflict_cnt), 32'h0);
        run = 1'b1;

        for (int i = 0; i < v.size(); i++) begin
            reset = v[i].rst;
            bus.req = v[i].req;
            bus.addr = {v[i].a1, v[i].a0};
            bus.data = {v[i].d1, v[i].d0};
`ifdef REGARB_CONFLICT_CNT_EN
            ecnt = v[i].rst ? 16'h0 : v[i].conf ? ecnt + 16'd1 : ecnt;
`endif
            e.g = v[i].g; e.en = v[i].en; e.dat = v[i].dat; e.cnt = ecnt;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard step %0d: queue empty", i);
            end else begin
                e = sb.pop_front();
                chk("gnt", i, 32'(bus.gnt), 32'(e.g));
                chk("reg_en", i, bus.reg_en, e.en);
                chk("reg_data", i, bus.reg_data, e.dat);
                chk("conflict_cnt", i, 32'(bus.conflict_cnt), 32'(e.cnt));
            end
        end
        run = 1'b0;
        reset = 1'b0;
        bus.req = '0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
